// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port, fixed-latency SRAM between instruction fetch and the data stage.
// Optional single-entry fetch buffer when ARB_FETCH_BUF_EN is defined.
module imem_dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_freeze,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_stall,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [0:0]        dbg_state
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  // Handshake: each requester holds req high until its one-cycle ready pulse;
  // the arbiter samples address/we/wdata only at grant and keeps them stable
  // on the SRAM side for the whole access.

  logic [0:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;   // 1 = MEM, 0 = IF
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;

  logic access_done, if_done, mem_done;
  logic grant_mem, grant_if;
  logic fetch_hit, hit_q;

  assign access_done = (state_q == S_ACCESS) && (cnt_q == 4'd0);
  assign if_done     = access_done && !owner_q;
  assign mem_done    = access_done && owner_q;
  assign grant_mem   = (state_q == S_IDLE) && mem_req;
  assign grant_if    = (state_q == S_IDLE) && !mem_req && if_req && !hit_q && !fetch_hit;

`ifdef ARB_FETCH_BUF_EN
  logic              buf_valid_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [DATA_W-1:0] buf_data_q;

  // hit_q blocks a second hit/grant in the cycle the buffered ready is returned
  assign fetch_hit = (state_q == S_IDLE) && !mem_req && if_req && !hit_q &&
                     buf_valid_q && (buf_addr_q == if_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      hit_q       <= 1'b0;
    end else begin
      hit_q <= fetch_hit;
      if (if_done) begin
        buf_valid_q <= 1'b1;
        buf_addr_q  <= addr_q;
        buf_data_q  <= sram_rdata;
      end else if (grant_mem && mem_we && (mem_addr == buf_addr_q)) begin
        buf_valid_q <= 1'b0;
      end
    end
  end
`else
  assign fetch_hit = 1'b0;
  assign hit_q     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_mem) begin
          state_d = S_ACCESS;
          cnt_d   = WAIT_INIT;
          owner_d = 1'b1;
          addr_d  = mem_addr;
          we_d    = mem_we;
          wdata_d = mem_wdata;
        end else if (grant_if) begin
          state_d = S_ACCESS;
          cnt_d   = WAIT_INIT;
          owner_d = 1'b0;
          addr_d  = if_addr;
          we_d    = 1'b0;
          wdata_d = '0;
        end
      end
      S_ACCESS: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      if (if_done) if_rdata_q <= sram_rdata;
`ifdef ARB_FETCH_BUF_EN
      else if (fetch_hit) if_rdata_q <= buf_data_q;
`endif
      if (mem_done && !we_q) mem_rdata_q <= sram_rdata;
    end
  end

  // Read data is forwarded combinationally in the completion cycle, then held.
  assign if_ready   = if_done || hit_q;
  assign if_rdata   = if_done ? sram_rdata : if_rdata_q;
  assign mem_ready  = mem_done;
  assign mem_rdata  = (mem_done && !we_q) ? sram_rdata : mem_rdata_q;
  assign if_freeze  = rst && if_req && !if_ready;
  assign mem_stall  = rst && mem_req && !mem_ready;
  assign sram_en    = (state_q == S_ACCESS);
  assign sram_we    = sram_en && we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances with SRAM models.
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic        sel;

  logic [31:0] if_rdata_2, mem_rdata_2, sram_addr_2, sram_wdata_2, sram_rdata_2;
  logic        if_ready_2, if_freeze_2, mem_ready_2, mem_stall_2, sram_en_2, sram_we_2;
  logic [0:0]  dbg_2;
  logic [31:0] if_rdata_0, mem_rdata_0, sram_addr_0, sram_wdata_0, sram_rdata_0;
  logic        if_ready_0, if_freeze_0, mem_ready_0, mem_stall_0, sram_en_0, sram_we_0;
  logic [0:0]  dbg_0;

  logic [31:0] m2 [0:255];
  logic [31:0] m0 [0:255];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_2), .if_ready(if_ready_2),
    .if_freeze(if_freeze_2),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata_2), .mem_ready(mem_ready_2), .mem_stall(mem_stall_2),
    .sram_en(sram_en_2), .sram_we(sram_we_2), .sram_addr(sram_addr_2),
    .sram_wdata(sram_wdata_2), .sram_rdata(sram_rdata_2), .dbg_state(dbg_2)
  );

  imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_0), .if_ready(if_ready_0),
    .if_freeze(if_freeze_0),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata_0), .mem_ready(mem_ready_0), .mem_stall(mem_stall_0),
    .sram_en(sram_en_0), .sram_we(sram_we_0), .sram_addr(sram_addr_0),
    .sram_wdata(sram_wdata_0), .sram_rdata(sram_rdata_0), .dbg_state(dbg_0)
  );

  // SRAM models: word-addressed, read data combinational from the held address
  assign sram_rdata_2 = m2[sram_addr_2[9:2]];
  assign sram_rdata_0 = m0[sram_addr_0[9:2]];
  always @(posedge clk) if (sram_en_2 && sram_we_2) m2[sram_addr_2[9:2]] <= sram_wdata_2;
  always @(posedge clk) if (sram_en_0 && sram_we_0) m0[sram_addr_0[9:2]] <= sram_wdata_0;

  // Observed instance selected by sel (0 = WAIT_CYCLES 2, 1 = WAIT_CYCLES 0)
  logic [31:0] o_if_rdata, o_mem_rdata, o_sram_addr;
  logic        o_if_ready, o_if_freeze, o_mem_ready, o_mem_stall, o_sram_en, o_sram_we;
  always_comb begin
    o_if_rdata  = sel ? if_rdata_0  : if_rdata_2;
    o_mem_rdata = sel ? mem_rdata_0 : mem_rdata_2;
    o_sram_addr = sel ? sram_addr_0 : sram_addr_2;
    o_if_ready  = sel ? if_ready_0  : if_ready_2;
    o_if_freeze = sel ? if_freeze_0 : if_freeze_2;
    o_mem_ready = sel ? mem_ready_0 : mem_ready_2;
    o_mem_stall = sel ? mem_stall_0 : mem_stall_2;
    o_sram_en   = sel ? sram_en_0   : sram_en_2;
    o_sram_we   = sel ? sram_we_0   : sram_we_2;
  end

  typedef struct {
    bit          do_if;
    bit          do_mem;
    bit          we;
    logic [31:0] if_addr;
    logic [31:0] mem_addr;
    logic [31:0] wdata;
    int          exp_if_at;
    logic [31:0] exp_if_d;
    int          exp_mem_at;
    logic [31:0] exp_mem_d;
    int          exp_en;
    int          exp_we;
  } txn_t;

  txn_t vec [8];

  function automatic txn_t mk(bit di, bit dm, bit we, logic [31:0] ia, logic [31:0] ma,
                              logic [31:0] wd, int ia_t, logic [31:0] id, int ma_t,
                              logic [31:0] md, int en, int wn);
    txn_t t;
    t.do_if = di; t.do_mem = dm; t.we = we; t.if_addr = ia; t.mem_addr = ma; t.wdata = wd;
    t.exp_if_at = ia_t; t.exp_if_d = id; t.exp_mem_at = ma_t; t.exp_mem_d = md;
    t.exp_en = en; t.exp_we = wn;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // Runs one transaction; cycle 0 is the cycle in which the requests are first seen
  task automatic run_txn(input txn_t t, output int if_at, output int mem_at,
                         output logic [31:0] if_d, output logic [31:0] mem_d,
                         output int en_n, output int we_n, output int frz_n, output int stl_n);
    if_at = -1; mem_at = -1; if_d = '0; mem_d = '0;
    en_n = 0; we_n = 0; frz_n = 0; stl_n = 0;
    @(posedge clk); #1;
    if_req = t.do_if; if_addr = t.if_addr;
    mem_req = t.do_mem; mem_we = t.we; mem_addr = t.mem_addr; mem_wdata = t.wdata;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o_sram_en)   en_n++;
      if (o_sram_we)   we_n++;
      if (o_if_freeze) frz_n++;
      if (o_mem_stall) stl_n++;
      if (o_if_ready && if_at < 0)   begin if_at = c;  if_d = o_if_rdata;   end
      if (o_mem_ready && mem_at < 0) begin mem_at = c; mem_d = o_mem_rdata; end
      @(posedge clk); #1;
      if (if_at >= 0)  if_req = 1'b0;
      if (mem_at >= 0) mem_req = 1'b0;
      if ((if_at >= 0 || !t.do_if) && (mem_at >= 0 || !t.do_mem)) break;
    end
    if_req = 1'b0; mem_req = 1'b0;
  endtask

  initial begin
    int          if_at, mem_at, en_n, we_n, frz_n, stl_n, k, rdy_seen, lat;
    logic [31:0] if_d, mem_d, rd;
    logic [31:0] s_addr [3];
    logic [31:0] s_data [3];

    for (int i = 0; i < 256; i++) begin
      m2[i] = 32'h5000_0000 + 32'(i);
      m0[i] = 32'h5000_0000 + 32'(i);
    end
    m2[4]  = 32'hE3A0_1005; m2[5] = 32'h1111_1111; m2[16] = 32'hDEAD_BEEF; m2[8] = 32'h1234_5678;
    m0[0]  = 32'h0000_0AA0; m0[1] = 32'h0000_0AA4; m0[2] = 32'h0000_0AA8;
    s_addr[0] = 32'h0; s_addr[1] = 32'h4; s_addr[2] = 32'h8;
    s_data[0] = 32'h0000_0AA0; s_data[1] = 32'h0000_0AA4; s_data[2] = 32'h0000_0AA8;

    vec[0] = mk(1, 0, 0, 32'h10, 32'h0,  32'h0,         3, 32'hE3A0_1005, 0, 32'h0,         3, 0);
    vec[1] = mk(1, 1, 0, 32'h14, 32'h40, 32'h0,         7, 32'h1111_1111, 3, 32'hDEAD_BEEF, 6, 0);
    vec[2] = mk(0, 1, 1, 32'h0,  32'h80, 32'hCAFE_F00D, 0, 32'h0,         3, 32'hDEAD_BEEF, 3, 3);
    vec[3] = mk(0, 1, 0, 32'h0,  32'h80, 32'h0,         0, 32'h0,         3, 32'hCAFE_F00D, 3, 0);
    vec[4] = mk(1, 0, 0, 32'h20, 32'h0,  32'h0,         3, 32'h1234_5678, 0, 32'h0,         3, 0);
`ifdef ARB_FETCH_BUF_EN
    vec[5] = mk(1, 0, 0, 32'h20, 32'h0,  32'h0,         1, 32'h1234_5678, 0, 32'h0,         0, 0);
`else
    vec[5] = mk(1, 0, 0, 32'h20, 32'h0,  32'h0,         3, 32'h1234_5678, 0, 32'h0,         3, 0);
`endif
    vec[6] = mk(0, 1, 1, 32'h0,  32'h20, 32'hA5A5_A5A5, 0, 32'h0,         3, 32'hCAFE_F00D, 3, 3);
    vec[7] = mk(1, 0, 0, 32'h20, 32'h0,  32'h0,         3, 32'hA5A5_A5A5, 0, 32'h0,         3, 0);

    // Reset with both requests high: every output must read zero
    sel = 1'b0; rst = 1'b0;
    if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0;
    if_addr = 32'h10; mem_addr = 32'h40; mem_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_sram_en",   32'(o_sram_en), 32'd0);
    check("rst_readies",   {30'd0, o_if_ready, o_mem_ready}, 32'd0);
    check("rst_frz_stall", {30'd0, o_if_freeze, o_mem_stall}, 32'd0);
    check("rst_if_rdata",  o_if_rdata, 32'd0);
    check("rst_mem_rdata", o_mem_rdata, 32'd0);
    check("rst_sram_addr", o_sram_addr, 32'd0);
    if_req = 1'b0; mem_req = 1'b0;
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_txn(vec[i], if_at, mem_at, if_d, mem_d, en_n, we_n, frz_n, stl_n);
      if (vec[i].do_if) begin
        check($sformatf("v%0d_if_at", i),     32'(if_at), 32'(vec[i].exp_if_at));
        check($sformatf("v%0d_if_rdata", i),  if_d, vec[i].exp_if_d);
        check($sformatf("v%0d_freeze_n", i),  32'(frz_n), 32'(vec[i].exp_if_at));
      end
      if (vec[i].do_mem) begin
        check($sformatf("v%0d_mem_at", i),    32'(mem_at), 32'(vec[i].exp_mem_at));
        check($sformatf("v%0d_mem_rdata", i), mem_d, vec[i].exp_mem_d);
        check($sformatf("v%0d_stall_n", i),   32'(stl_n), 32'(vec[i].exp_mem_at));
      end
      check($sformatf("v%0d_en_n", i), 32'(en_n), 32'(vec[i].exp_en));
      check($sformatf("v%0d_we_n", i), 32'(we_n), 32'(vec[i].exp_we));
    end

    // Reset in the middle of a MEM read (counter = 1), then restart from grant
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40;
    rdy_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_mem_ready) rdy_seen++;
    end
    check("abort_pre_en", 32'(o_sram_en), 32'd1);
    rst = 1'b0; #1;
    check("abort_sram_en",   32'(o_sram_en), 32'd0);
    check("abort_stall",     32'(o_mem_stall), 32'd0);
    check("abort_mem_rdata", o_mem_rdata, 32'd0);
    check("abort_sram_addr", o_sram_addr, 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (o_mem_ready) rdy_seen++;
    end
    check("abort_no_ready", 32'(rdy_seen), 32'd0);
    rst = 1'b1;
    lat = -1; rd = '0;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      if (o_mem_ready) begin lat = c; rd = o_mem_rdata; break; end
    end
    check("restart_lat",   32'(lat), 32'd3);
    check("restart_rdata", rd, 32'hDEAD_BEEF);
    @(posedge clk); #1; mem_req = 1'b0;
    repeat (4) @(posedge clk);

    // WAIT_CYCLES=0 instance: fetch held high across addresses 0, 4, 8
    sel = 1'b1;
    #1; if_req = 1'b1; if_addr = s_addr[0];
    k = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (o_if_ready) begin
        check($sformatf("w0_cycle%0d", k), 32'(c), 32'(2 * k + 1));
        check($sformatf("w0_rdata%0d", k), o_if_rdata, s_data[k]);
        k++;
      end
      @(posedge clk); #1;
      if (k == 3) begin if_req = 1'b0; break; end
      if_addr = s_addr[k];
    end
    check("w0_count", 32'(k), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port, fixed-latency SRAM between the fetch stage (instruction reads) and the memory stage (data reads/writes).
- Sits between the IF/MEM pipeline stages and the external SRAM model.
- Sequences each SRAM access with a wait-state counter, returns a ready pulse per requester, and produces the freeze/stall signals that hold the PC register and the pipeline.

Parameters:
ADDR_W, 32, address width for both requesters and the SRAM
DATA_W, 32, data width
WAIT_CYCLES, 2, SRAM wait states; legal range 0..15

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
if_req  input  1  fetch read request, level-held until if_ready
if_addr  input  ADDR_W  fetch address (current PC)
if_rdata  output  DATA_W  fetched instruction, valid with if_ready and held after it
if_ready  output  1  one-cycle pulse: fetch access complete
if_freeze  output  1  freeze to PC register = if_req & ~if_ready
mem_req  input  1  data request, level-held until mem_ready
mem_we  input  1  1 = write, 0 = read; sampled at grant
mem_addr  input  ADDR_W  data address
mem_wdata  input  DATA_W  write data
mem_rdata  output  DATA_W  read data, valid with mem_ready and held after it
mem_ready  output  1  one-cycle pulse: data access complete
mem_stall  output  1  whole-pipeline stall = mem_req & ~mem_ready
sram_en  output  1  SRAM access active
sram_we  output  1  SRAM write enable
sram_addr  output  ADDR_W  SRAM address
sram_wdata  output  DATA_W  SRAM write data
sram_rdata  input  DATA_W  SRAM read data, valid in the final wait cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - Wait counter = 0.
  - All outputs = 0, including if_rdata and mem_rdata.
- FSM states: IDLE, ACCESS.
- IDLE grant:
  - If mem_req=1, grant MEM. The data stage is older and always wins.
  - Otherwise, if if_req=1, grant IF.
  - On a grant: latch owner, address, we and wdata; set counter = WAIT_CYCLES; go to ACCESS.
  - If no request, stay in IDLE.
- ACCESS:
  - sram_en = 1.
  - sram_addr, sram_we and sram_wdata are driven from the latched values and are stable for the whole access.
  - sram_we = 0 for IF grants.
  - If counter != 0: decrement and stay.
  - If counter == 0: capture sram_rdata into the owner's rdata register (reads only), pulse the owner's ready for one cycle, and return to IDLE.
- Latency: request sampled in IDLE at cycle N -> ready asserted in cycle N+WAIT_CYCLES+1.
  - WAIT_CYCLES=0 gives ready on cycle N+1.
- Back-to-back accesses: a one-cycle IDLE gap follows each completion, in which the next grant is taken.
- Simultaneous if_req and mem_req: MEM is served first and IF waits.
  - IF is served in the next IDLE if mem_req has dropped.
  - If mem_req is still high in that IDLE, MEM wins again. Fetch starvation is acceptable because the pipeline is stalled while MEM is active.
- A request deasserted mid-access: the access still completes and the ready pulse is still issued.
- rdata registers hold their last value until the next completed read for that requester.
- Write completions do not alter mem_rdata.
- Reset asserted mid-access: the access is aborted immediately, no ready pulse is issued, and sram_en drops asynchronously.
- Addresses are passed through unmodified: no alignment check and no wrap logic.

Optional Feature:
- Macro: ARB_FETCH_BUF_EN.
- Defined: adds a single-entry fetch buffer holding {valid, addr, data}.
  - Fill: loaded on every completed IF read.
  - Hit: in IDLE, with if_req=1, mem_req=0, valid=1 and addr==if_addr, the arbiter returns if_rdata from the buffer and pulses if_ready in the next cycle.
  - On a hit there is no SRAM access and the FSM stays in IDLE.
  - Invalidation: any MEM write whose address equals the buffered address clears valid.
  - Reset clears valid.
- Not defined: no buffer; every fetch goes to SRAM.

Test Plan:
- WAIT_CYCLES=2; if_req=1, if_addr=0x10, SRAM word 0x10=0xE3A01005 -> sram_en high for 3 cycles, if_ready pulses at cycle N+3, if_rdata=0xE3A01005, and if_freeze=1 for cycles N..N+2.
- if_req and mem_req rise in the same cycle, with mem read of 0x40 (SRAM 0x40=0xDEADBEEF) -> MEM granted first, and mem_ready plus mem_rdata=0xDEADBEEF at N+3. mem_req drops at N+3 (cycle of mem_ready) -> IF granted in the IDLE cycle N+4, and if_ready at N+7.
- mem write of 0xCAFEF00D to 0x80, then mem read of 0x80 -> sram_we=1 only during the write access, and the read returns 0xCAFEF00D.
- WAIT_CYCLES=0; continuous if_req to addresses 0,4,8 -> if_ready every 2nd cycle with correct data.
- rst pulled low in the middle of a MEM access (counter=1) -> all outputs 0 immediately, and no mem_ready. After rst=1 with mem_req still high -> the access restarts from grant.
- ARB_FETCH_BUF_EN: fetch 0x20 twice -> the second fetch gives if_ready one cycle after the request with no sram_en. Then a mem write to 0x20 followed by a fetch of 0x20 -> full SRAM access with the new data.
